// File: rtl/chase_pkg.sv
// chase_pkg: states, tuning constants and the command clamp shared by
// chase_supervisor and its optional speed slew limiter.
package chase_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        CHASE  = 3'd2,
        COAST  = 3'd3,
        SEARCH = 3'd4,
        HALT   = 3'd5
    } chase_state_t;

    localparam logic [8:0]        NO_BLOB_X      = 9'h1FF;
    localparam int                SOFTSTART_STEP = 16;
    localparam logic [6:0]        MIN_RAD        = 7'd7;
    localparam logic [2:0]        ARM_FRAMES     = 3'd4;
    localparam logic [2:0]        REACQ_FRAMES   = 3'd2;
    localparam logic [7:0]        COAST_FRAMES   = 8'd8;
    localparam logic [7:0]        SEARCH_FRAMES  = 8'd90;
    localparam logic [7:0]        HALT_LOST      = COAST_FRAMES + SEARCH_FRAMES;
    localparam logic signed [8:0] SEARCH_TURN    = 9'sd40;
    localparam logic signed [8:0] MAX_CMD        = 9'sd200;
    localparam logic [8:0]        X_MID          = 9'd160;

    // Symmetric saturation of a signed motor command to +/-MAX_CMD.
    function automatic logic signed [8:0] clamp_cmd(input logic signed [8:0] v);
        if (v > MAX_CMD)       return MAX_CMD;
        else if (v < -MAX_CMD) return -MAX_CMD;
        else                   return v;
    endfunction

endpackage

// File: rtl/cmd_slew_limiter.sv
// cmd_slew_limiter: moves a signed 9-bit command toward its target by at
// most SOFTSTART_STEP per step pulse; zero_in snaps the output to 0.
module cmd_slew_limiter
    import chase_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              step_in,
    input  logic              zero_in,
    input  logic signed [8:0] target_in,
    output logic signed [8:0] value_out
);

    localparam logic signed [9:0] STEP = 10'(SOFTSTART_STEP);

    logic signed [8:0] value_q, value_d;
    logic signed [9:0] diff;

    // Next value: forced zero wins, otherwise one bounded step per frame.
    always_comb begin
        value_d = value_q;
        diff    = $signed({target_in[8], target_in}) - $signed({value_q[8], value_q});
        if (zero_in) begin
            value_d = '0;
        end else if (step_in) begin
            if (diff > STEP)       value_d = 9'(value_q + STEP);
            else if (diff < -STEP) value_d = 9'(value_q - STEP);
            else                   value_d = target_in;
        end
    end

    // Output register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value_out = value_q;

endmodule

// File: rtl/chase_supervisor.sv
// chase_supervisor: frame-rate mode scheduler between the tracker and the
// motor driver. Decides once per camera frame whether control commands reach
// the motors or the bot coasts, searches or halts.
// Optional soft start of speed_out: define CHASE_SOFTSTART_EN.
module chase_supervisor
    import chase_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_done_in,
    input  logic              arm_in,
    input  logic              track_in,
    input  logic              pause_in,
    input  logic [8:0]        x_in,
    input  logic [6:0]        rad_in,
    input  logic signed [8:0] speed_in,
    input  logic signed [8:0] turn_in,
    output logic              ctrl_ready_out,
    output logic signed [8:0] speed_out,
    output logic signed [8:0] turn_out,
    output logic              motor_en_out,
    output logic [2:0]        state_out,
    output logic [7:0]        lost_cnt_out
);

    chase_state_t      state_q, state_d;
    logic [2:0]        vcnt_q, vcnt_d;          // consecutive valid frames
    logic [7:0]        lost_q, lost_d;          // consecutive lost frames
    logic [8:0]        last_x_q, last_x_d;
    logic signed [8:0] cmd_speed_q, cmd_speed_d; // last clamped CHASE commands
    logic signed [8:0] cmd_turn_q, cmd_turn_d;
    logic signed [8:0] speed_q, speed_d;
    logic signed [8:0] turn_q, turn_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;

    logic       go_idle, frame_valid;
    logic [2:0] vcnt_inc;
    logic [7:0] lost_inc;

    assign go_idle     = !arm_in || !track_in;
    assign frame_valid = (x_in != NO_BLOB_X) && (rad_in >= MIN_RAD);
    assign vcnt_inc    = (vcnt_q == 3'd7)  ? vcnt_q : vcnt_q + 3'd1;
    assign lost_inc    = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

    // Next-state, counters and next outputs; priority: disarm, pause, frame.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        vcnt_d      = vcnt_q;
        lost_d      = lost_q;
        last_x_d    = last_x_q;
        cmd_speed_d = cmd_speed_q;
        cmd_turn_d  = cmd_turn_q;
        speed_d     = speed_q;
        turn_d      = turn_q;
        en_d        = en_q;
        ready_d     = 1'b0;

        if (go_idle) begin
            state_d     = IDLE;
            vcnt_d      = '0;
            lost_d      = '0;
            cmd_speed_d = '0;
            cmd_turn_d  = '0;
            speed_d     = '0;
            turn_d      = '0;
            en_d        = 1'b0;
        end else if (pause_in) begin
            speed_d = '0;
            turn_d  = '0;
            en_d    = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ARMED;
        end else if (frame_done_in) begin
            ready_d = (state_q == ARMED) || (state_q == CHASE);
            vcnt_d  = frame_valid ? vcnt_inc : 3'd0;
            lost_d  = frame_valid ? 8'd0 : lost_inc;

            case (state_q)
                ARMED:  if (frame_valid && vcnt_inc == ARM_FRAMES) state_d = CHASE;
                CHASE:  if (!frame_valid) state_d = COAST;
                COAST:  if (frame_valid) state_d = CHASE;
                        else if (lost_inc == COAST_FRAMES) state_d = SEARCH;
                SEARCH: if (frame_valid && vcnt_inc == REACQ_FRAMES) state_d = CHASE;
                        else if (!frame_valid && lost_inc == HALT_LOST) state_d = HALT;
                default: ;
            endcase

            // Only a valid frame can land in CHASE, so its x and commands are live.
            if (state_d == CHASE) begin
                cmd_speed_d = clamp_cmd(speed_in);
                cmd_turn_d  = clamp_cmd(turn_in);
                last_x_d    = x_in;
            end

            case (state_d)
                CHASE: begin
                    speed_d = cmd_speed_d;
                    turn_d  = cmd_turn_d;
                    en_d    = 1'b1;
                end
                COAST: begin
                    speed_d = cmd_speed_d >>> 1;
                    turn_d  = cmd_turn_d;
                    en_d    = 1'b1;
                end
                SEARCH: begin
                    speed_d = '0;
                    turn_d  = (last_x_d < X_MID) ? -SEARCH_TURN : SEARCH_TURN;
                    en_d    = 1'b1;
                end
                default: begin
                    speed_d = '0;
                    turn_d  = '0;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) begin
            state_q     <= IDLE;
            vcnt_q      <= '0;
            lost_q      <= '0;
            last_x_q    <= X_MID;
            cmd_speed_q <= '0;
            cmd_turn_q  <= '0;
            speed_q     <= '0;
            turn_q      <= '0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vcnt_q      <= vcnt_d;
            lost_q      <= lost_d;
            last_x_q    <= last_x_d;
            cmd_speed_q <= cmd_speed_d;
            cmd_turn_q  <= cmd_turn_d;
            speed_q     <= speed_d;
            turn_q      <= turn_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
        end
    end

`ifdef CHASE_SOFTSTART_EN
    logic speed_step, speed_zero;
    assign speed_step = frame_done_in && !go_idle && !pause_in && (state_q != IDLE);
    assign speed_zero = go_idle || pause_in || (speed_step && state_d == HALT);

    cmd_slew_limiter u_speed_slew (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .step_in   (speed_step),
        .zero_in   (speed_zero),
        .target_in (speed_d),
        .value_out (speed_out)
    );
`else
    assign speed_out = speed_q;
`endif

    assign turn_out       = turn_q;
    assign motor_en_out   = en_q;
    assign ctrl_ready_out = ready_q;
    assign state_out      = state_q;
    assign lost_cnt_out   = lost_q;

endmodule

// File: tb/tb_chase_supervisor.sv
// tb_chase_supervisor: directed stimulus for chase_supervisor with a
// frame-level behavioural model compared on every falling clock edge, plus
// literal expectations at the key points of each scenario.
module tb_chase_supervisor;

    localparam int NOB = 511;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              frame_done_in, arm_in, track_in, pause_in;
    logic [8:0]        x_in;
    logic [6:0]        rad_in;
    logic signed [8:0] speed_in, turn_in;
    logic              ctrl_ready_out, motor_en_out;
    logic signed [8:0] speed_out, turn_out;
    logic [2:0]        state_out;
    logic [7:0]        lost_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    chase_supervisor dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_done_in  (frame_done_in),
        .arm_in         (arm_in),
        .track_in       (track_in),
        .pause_in       (pause_in),
        .x_in           (x_in),
        .rad_in         (rad_in),
        .speed_in       (speed_in),
        .turn_in        (turn_in),
        .ctrl_ready_out (ctrl_ready_out),
        .speed_out      (speed_out),
        .turn_out       (turn_out),
        .motor_en_out   (motor_en_out),
        .state_out      (state_out),
        .lost_cnt_out   (lost_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (frame-level rules) ----------------
    int m_state = 0, m_run = 0, m_lost = 0, m_last_x = 160, m_cs = 0, m_ct = 0;
    int e_speed = 0, e_turn = 0, e_en = 0, e_ready = 0;

    function automatic int clampv(input int v);
        if (v > 200)  return 200;
        if (v < -200) return -200;
        return v;
    endfunction

    function automatic int floor_half(input int v);
        return (v >= 0) ? v / 2 : -((-v + 1) / 2);
    endfunction

    always @(posedge clk_in or posedge rst_in) begin : model
        bit valid;
        if (rst_in) begin
            m_state = 0; m_run = 0; m_lost = 0; m_last_x = 160; m_cs = 0; m_ct = 0;
            e_speed = 0; e_turn = 0; e_en = 0; e_ready = 0;
        end else begin
            e_ready = 0;
            valid = (int'(x_in) != NOB) && (int'(rad_in) >= 7);
            if (!arm_in || !track_in) begin
                m_state = 0; m_run = 0; m_lost = 0; m_cs = 0; m_ct = 0;
                e_speed = 0; e_turn = 0; e_en = 0;
            end else if (pause_in) begin
                e_speed = 0; e_turn = 0; e_en = 0;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (frame_done_in) begin
                e_ready = (m_state == 1 || m_state == 2) ? 1 : 0;
                if (valid) begin
                    m_run++;
                    m_lost = 0;
                end else begin
                    m_run = 0;
                    if (m_lost < 255) m_lost++;
                end
                if (m_state == 1 && m_run >= 4) m_state = 2;
                else if (m_state == 2 && !valid) m_state = 3;
                else if (m_state == 3 && valid) m_state = 2;
                else if (m_state == 3 && m_lost >= 8) m_state = 4;
                else if (m_state == 4 && valid && m_run >= 2) m_state = 2;
                else if (m_state == 4 && !valid && m_lost >= 98) m_state = 5;
                if (m_state == 2) begin
                    m_cs = clampv(int'(speed_in));
                    m_ct = clampv(int'(turn_in));
                    m_last_x = int'(x_in);
                end
                e_speed = 0; e_turn = 0; e_en = 0;
                if (m_state == 2) begin
                    e_speed = m_cs; e_turn = m_ct; e_en = 1;
                end else if (m_state == 3) begin
                    e_speed = floor_half(m_cs); e_turn = m_ct; e_en = 1;
                end else if (m_state == 4) begin
                    e_turn = (m_last_x < 160) ? -40 : 40; e_en = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_in) begin
        check("cyc speed", speed_out, e_speed);
        check("cyc turn", turn_out, e_turn);
        check("cyc en", motor_en_out, e_en);
        check("cyc ready", ctrl_ready_out, e_ready);
        check("cyc state", state_out, m_state);
        check("cyc lost", lost_cnt_out, m_lost);
    end

    // ---------------- stimulus ----------------
    task automatic frame(input int x, input int rad, input int sp, input int tn);
        repeat (2) @(posedge clk_in);
        #1;
        x_in          = 9'(x);
        rad_in        = 7'(rad);
        speed_in      = 9'(sp);
        turn_in       = 9'(tn);
        frame_done_in = 1'b1;
        @(posedge clk_in);
        #1;
        frame_done_in = 1'b0;
    endtask

    task automatic arm_to_chase(input int x, input int sp, input int tn);
        arm_in   = 1'b1;
        track_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("armed state", state_out, 1);
        for (int i = 0; i < 4; i++) begin
            frame(x, 20, sp, tn);
            check("arm ready", ctrl_ready_out, 1);
        end
        check("chase state", state_out, 2);
    endtask

    initial begin
        rst_in = 1'b0; arm_in = 1'b0; track_in = 1'b0; pause_in = 1'b0;
        frame_done_in = 1'b0; x_in = 9'h1FF; rad_in = '0; speed_in = '0; turn_in = '0;
        #1 rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset state", state_out, 0);
        check("reset speed", speed_out, 0);
        check("reset en", motor_en_out, 0);
        check("reset lost", lost_cnt_out, 0);
        rst_in = 1'b0;

        // Arm: ARMED for 3 frames, CHASE after the 4th with live commands.
        arm_in   = 1'b1;
        track_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("armed state", state_out, 1);
        for (int i = 0; i < 4; i++) begin
            frame(100, 20, 100, 30);
            check("arm ready", ctrl_ready_out, 1);
            if (i < 3) check("armed hold", state_out, 1);
        end
        check("chase state", state_out, 2);
        check("chase en", motor_en_out, 1);
        check("chase speed", speed_out, 100);
        check("chase turn", turn_out, 30);

        // Clamp.
        frame(100, 20, 250, -230);
        check("clamp speed", speed_out, 200);
        check("clamp turn", turn_out, -200);
        frame(100, 20, 100, 30);
        check("speed 100", speed_out, 100);

        // Loss: COAST at half speed, SEARCH after 8 lost frames.
        frame(NOB, 20, 0, 0);
        check("coast state", state_out, 3);
        check("coast speed", speed_out, 50);
        check("coast turn", turn_out, 30);
        check("coast lost", lost_cnt_out, 1);
        for (int i = 0; i < 7; i++) frame(NOB, 20, 0, 0);
        check("search state", state_out, 4);
        check("search speed", speed_out, 0);
        check("search turn", turn_out, -40);
        check("search lost", lost_cnt_out, 8);

        // Halt at lost == 98, saturation at 255, disarm to IDLE.
        for (int i = 0; i < 89; i++) frame(NOB, 20, 0, 0);
        check("pre-halt state", state_out, 4);
        check("pre-halt lost", lost_cnt_out, 97);
        frame(NOB, 20, 0, 0);
        check("halt state", state_out, 5);
        check("halt lost", lost_cnt_out, 98);
        check("halt en", motor_en_out, 0);
        check("halt turn", turn_out, 0);
        for (int i = 0; i < 160; i++) frame(NOB, 20, 0, 0);
        check("lost sat", lost_cnt_out, 255);
        check("halt held", state_out, 5);
        arm_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("disarm state", state_out, 0);
        check("disarm lost", lost_cnt_out, 0);

        // Priority: frame and disarm on the same cycle.
        arm_to_chase(100, 100, 30);
        repeat (2) @(posedge clk_in);
        #1;
        x_in = 9'd100; rad_in = 7'd20;
        frame_done_in = 1'b1;
        arm_in        = 1'b0;
        @(posedge clk_in);
        #1;
        frame_done_in = 1'b0;
        check("prio state", state_out, 0);
        check("prio ready", ctrl_ready_out, 0);
        check("prio en", motor_en_out, 0);

        // Pause: commands zero, state and counters frozen, resume at next frame.
        arm_to_chase(100, 120, -20);
        check("pre-pause speed", speed_out, 120);
        pause_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("pause speed", speed_out, 0);
        check("pause en", motor_en_out, 0);
        check("pause state", state_out, 2);
        frame(NOB, 20, 0, 0);
        check("pause frame state", state_out, 2);
        check("pause frame ready", ctrl_ready_out, 0);
        check("pause frame lost", lost_cnt_out, 0);
        pause_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("unpause speed", speed_out, 0);
        check("unpause state", state_out, 2);
        frame(200, 20, -101, 50);
        check("resume speed", speed_out, -101);
        check("resume turn", turn_out, 50);
        check("resume en", motor_en_out, 1);

        // Negative coast, right-hand search, two-frame reacquire.
        frame(NOB, 20, 0, 0);
        check("neg coast speed", speed_out, -51);
        for (int i = 0; i < 7; i++) frame(NOB, 20, 0, 0);
        check("search right turn", turn_out, 40);
        frame(200, 20, -250, 10);
        check("reacq1 state", state_out, 4);
        check("reacq1 lost", lost_cnt_out, 0);
        frame(200, 20, -250, 10);
        check("reacq2 state", state_out, 2);
        check("reacq2 speed", speed_out, -200);
        check("reacq2 turn", turn_out, 10);
        frame(NOB, 20, 0, 0);
        check("coast2 state", state_out, 3);
        check("coast2 speed", speed_out, -100);

        // Asynchronous reset mid-COAST, checked before any clock edge.
        #2 rst_in = 1'b1;
        #1;
        check("async speed", speed_out, 0);
        check("async turn", turn_out, 0);
        check("async en", motor_en_out, 0);
        check("async state", state_out, 0);
        check("async lost", lost_cnt_out, 0);
        check("async ready", ctrl_ready_out, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
